// File: rtl/pe_id_config_loader.sv
// Snapshots PE-array X/Y IDs and LN_config on start, then streams them over a valid/ready bus.
// Optional build macro SKIP_DISABLED_EN drops all-ones ("unused PE/row") Y/X entries.
module pe_id_config_loader #(
  parameter int unsigned ROWS = 6,
  parameter int unsigned COLS = 8,
  parameter int unsigned XW   = 5,
  parameter int unsigned YW   = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ROWS*COLS*XW-1:0]  filter_xid,
  input  logic [ROWS*COLS*XW-1:0]  ifmap_xid,
  input  logic [ROWS*COLS*XW-1:0]  ipsum_xid,
  input  logic [ROWS*COLS*XW-1:0]  opsum_xid,
  input  logic [ROWS*YW-1:0]       filter_yid,
  input  logic [ROWS*YW-1:0]       ifmap_yid,
  input  logic [ROWS*YW-1:0]       ipsum_yid,
  input  logic [ROWS*YW-1:0]       opsum_yid,
  input  logic [4:0]               ln_config,
  output logic                     busy,
  output logic                     cfg_valid,
  input  logic                     cfg_ready,
  output logic [2:0]               cfg_class,
  output logic                     cfg_is_x,
  output logic [2:0]               cfg_row,
  output logic [3:0]               cfg_col,
  output logic [4:0]               cfg_data,
  output logic                     cfg_last,
  output logic                     done
);

  localparam int unsigned NPE = ROWS * COLS;
  localparam int unsigned IW  = (NPE > 1) ? $clog2(NPE) : 1;

  typedef enum logic [2:0] {StIdle, StLoadY, StLoadX, StLoadLn, StDone} state_e;

  state_e        state_q, state_d;
  logic [1:0]    cls_q, cls_d;
  logic [2:0]    row_q, row_d;
  logic [3:0]    col_q, col_d;
  logic [IW-1:0] idx_q, idx_d;

  logic       valid_q, valid_d;
  logic [2:0] oclass_q, oclass_d;
  logic       is_x_q, is_x_d;
  logic [2:0] orow_q, orow_d;
  logic [3:0] ocol_q, ocol_d;
  logic [4:0] data_q, data_d;
  logic       last_q, last_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [XW-1:0] snap_x [4][NPE];
  logic [YW-1:0] snap_y [4][ROWS];
  logic [4:0]    snap_ln;
  logic          snap_en;

  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;
  logic          load_en;
  logic          skip;

  // Snapshot needs no reset: it is only read after a start has loaded it.
  always_ff @(posedge clk) begin
    if (snap_en) begin
      for (int i = 0; i < int'(NPE); i++) begin
        snap_x[0][i] <= filter_xid[i*XW +: XW];
        snap_x[1][i] <= ifmap_xid[i*XW +: XW];
        snap_x[2][i] <= ipsum_xid[i*XW +: XW];
        snap_x[3][i] <= opsum_xid[i*XW +: XW];
      end
      for (int r = 0; r < int'(ROWS); r++) begin
        snap_y[0][r] <= filter_yid[r*YW +: YW];
        snap_y[1][r] <= ifmap_yid[r*YW +: YW];
        snap_y[2][r] <= ipsum_yid[r*YW +: YW];
        snap_y[3][r] <= opsum_yid[r*YW +: YW];
      end
      snap_ln <= ln_config;
    end
  end

  assign cur_x = snap_x[cls_q][idx_q];
  assign cur_y = snap_y[cls_q][row_q];

  // The output register is a one-deep stage: refill when empty or being accepted.
  assign load_en = ~valid_q | cfg_ready;

`ifdef SKIP_DISABLED_EN
  assign skip = (state_q == StLoadY) ? (cur_y == '1) : (cur_x == '1);
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    row_d    = row_q;
    col_d    = col_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    oclass_d = oclass_q;
    is_x_d   = is_x_q;
    orow_d   = orow_q;
    ocol_d   = ocol_q;
    data_d   = data_q;
    last_d   = last_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    snap_en  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          snap_en = 1'b1;
          cls_d   = 2'd0;
          row_d   = 3'd0;
          col_d   = 4'd0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = StLoadY;
        end
      end

      StLoadY: begin
        if (load_en) begin
          valid_d = ~skip;
          if (!skip) begin
            oclass_d = {1'b0, cls_q};
            is_x_d   = 1'b0;
            orow_d   = row_q;
            ocol_d   = 4'd0;
            data_d   = 5'(cur_y);
            last_d   = 1'b0;
          end
          if (row_q == 3'(ROWS - 1)) begin
            row_d   = 3'd0;
            col_d   = 4'd0;
            idx_d   = '0;
            state_d = StLoadX;
          end else begin
            row_d = row_q + 3'd1;
          end
        end
      end

      StLoadX: begin
        if (load_en) begin
          valid_d = ~skip;
          if (!skip) begin
            oclass_d = {1'b0, cls_q};
            is_x_d   = 1'b1;
            orow_d   = row_q;
            ocol_d   = col_q;
            data_d   = 5'(cur_x);
            last_d   = 1'b0;
          end
          if (idx_q == IW'(NPE - 1)) begin
            row_d = 3'd0;
            col_d = 4'd0;
            idx_d = '0;
            if (cls_q == 2'd3) begin
              state_d = StLoadLn;
            end else begin
              cls_d   = cls_q + 2'd1;
              state_d = StLoadY;
            end
          end else begin
            idx_d = idx_q + IW'(1);
            if (col_q == 4'(COLS - 1)) begin
              col_d = 4'd0;
              row_d = row_q + 3'd1;
            end else begin
              col_d = col_q + 4'd1;
            end
          end
        end
      end

      StLoadLn: begin
        // last_q marks that the LN word already sits in the output register.
        if (valid_q && last_q) begin
          if (cfg_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end
        end else if (load_en) begin
          valid_d  = 1'b1;
          oclass_d = 3'd4;
          is_x_d   = 1'b0;
          orow_d   = 3'd0;
          ocol_d   = 4'd0;
          data_d   = snap_ln;
          last_d   = 1'b1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cls_q    <= 2'd0;
      row_q    <= 3'd0;
      col_q    <= 4'd0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      oclass_q <= 3'd0;
      is_x_q   <= 1'b0;
      orow_q   <= 3'd0;
      ocol_q   <= 4'd0;
      data_q   <= 5'd0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cls_q    <= cls_d;
      row_q    <= row_d;
      col_q    <= col_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      oclass_q <= oclass_d;
      is_x_q   <= is_x_d;
      orow_q   <= orow_d;
      ocol_q   <= ocol_d;
      data_q   <= data_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy      = busy_q;
  assign cfg_valid = valid_q;
  assign cfg_class = oclass_q;
  assign cfg_is_x  = is_x_q;
  assign cfg_row   = orow_q;
  assign cfg_col   = ocol_q;
  assign cfg_data  = data_q;
  assign cfg_last  = last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pe_id_config_loader.sv
// Scoreboard bench for pe_id_config_loader: stimulus pushes expected words, a negedge monitor
// pops and compares on every handshake.
module tb_pe_id_config_loader;

  localparam int ROWS = 6;
  localparam int COLS = 8;
  localparam int XW   = 5;
  localparam int YW   = 3;
  localparam int NPE  = ROWS * COLS;

  typedef struct packed {
    logic [2:0] cls;
    logic       is_x;
    logic [2:0] row;
    logic [3:0] col;
    logic [4:0] data;
    logic       last;
  } word_t;

  logic clk, rst_n, start, cfg_ready;
  logic [NPE*XW-1:0]  filter_xid, ifmap_xid, ipsum_xid, opsum_xid;
  logic [ROWS*YW-1:0] filter_yid, ifmap_yid, ipsum_yid, opsum_yid;
  logic [4:0] ln_config;
  logic busy, cfg_valid, cfg_is_x, cfg_last, done;
  logic [2:0] cfg_class, cfg_row;
  logic [3:0] cfg_col;
  logic [4:0] cfg_data;

  pe_id_config_loader #(.ROWS(ROWS), .COLS(COLS), .XW(XW), .YW(YW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .filter_xid (filter_xid),
    .ifmap_xid  (ifmap_xid),
    .ipsum_xid  (ipsum_xid),
    .opsum_xid  (opsum_xid),
    .filter_yid (filter_yid),
    .ifmap_yid  (ifmap_yid),
    .ipsum_yid  (ipsum_yid),
    .opsum_yid  (opsum_yid),
    .ln_config  (ln_config),
    .busy       (busy),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_class  (cfg_class),
    .cfg_is_x   (cfg_is_x),
    .cfg_row    (cfg_row),
    .cfg_col    (cfg_col),
    .cfg_data   (cfg_data),
    .cfg_last   (cfg_last),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  word_t exp_q[$];
  int    exp_gaps;
  int    hs_cnt, gap_cnt, done_cnt;
  bit    seen_first;
  bit    bp_mode = 1'b0;
  logic [15:0] lfsr = 16'hACE1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic word_t cur_word();
    return '{cls: cfg_class, is_x: cfg_is_x, row: cfg_row, col: cfg_col, data: cfg_data,
             last: cfg_last};
  endfunction

  function automatic logic [YW-1:0] get_y(int c, int r);
    case (c)
      0:       return filter_yid[r*YW +: YW];
      1:       return ifmap_yid[r*YW +: YW];
      2:       return ipsum_yid[r*YW +: YW];
      default: return opsum_yid[r*YW +: YW];
    endcase
  endfunction

  function automatic logic [XW-1:0] get_x(int c, int i);
    case (c)
      0:       return filter_xid[i*XW +: XW];
      1:       return ifmap_xid[i*XW +: XW];
      2:       return ipsum_xid[i*XW +: XW];
      default: return opsum_xid[i*XW +: XW];
    endcase
  endfunction

  function automatic bit is_skipped(logic [4:0] v, int w);
`ifdef SKIP_DISABLED_EN
    return (w == YW) ? (v == 5'd7) : (v == 5'd31);
`else
    return (v == 5'd31) && (w == 0);
`endif
  endfunction

  // Expected word stream, from the input values present at the start edge.
  task automatic push_expected();
    logic [4:0] v;
    exp_gaps = 0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        v = 5'(get_y(c, r));
        if (is_skipped(v, YW)) exp_gaps++;
        else exp_q.push_back('{cls: 3'(c), is_x: 1'b0, row: 3'(r), col: 4'd0, data: v, last: 1'b0});
      end
      for (int i = 0; i < NPE; i++) begin
        v = get_x(c, i);
        if (is_skipped(v, XW)) exp_gaps++;
        else exp_q.push_back('{cls: 3'(c), is_x: 1'b1, row: 3'(i / COLS), col: 4'(i % COLS),
                               data: v, last: 1'b0});
      end
    end
    exp_q.push_back('{cls: 3'd4, is_x: 1'b0, row: 3'd0, col: 4'd0, data: ln_config, last: 1'b1});
  endtask

  task automatic apply_pattern(input int sel);
    for (int i = 0; i < NPE; i++) begin
      if (sel == 1) begin
        filter_xid[i*XW +: XW] = 5'((i + 9) % 31);
        ifmap_xid[i*XW +: XW]  = 5'((i * 11 + 2) % 31);
        ipsum_xid[i*XW +: XW]  = 5'((i * 13 + 5) % 31);
        opsum_xid[i*XW +: XW]  = 5'((i * 17 + 4) % 31);
      end else begin
        filter_xid[i*XW +: XW] = 5'(i % 31);
        ifmap_xid[i*XW +: XW]  = 5'((i * 7 + 3) % 31);
        ipsum_xid[i*XW +: XW]  = 5'((47 - i) % 31);
        opsum_xid[i*XW +: XW]  = (sel == 2 && i >= 40) ? 5'd31 : 5'((i * 5 + 1) % 31);
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      if (sel == 1) begin
        filter_yid[r*YW +: YW] = 3'((r + 3) % 7);
        ifmap_yid[r*YW +: YW]  = 3'(r % 3);
        ipsum_yid[r*YW +: YW]  = 3'(6 - r);
        opsum_yid[r*YW +: YW]  = 3'((r * 2 + 1) % 7);
      end else begin
        filter_yid[r*YW +: YW] = 3'((r + 1) % 7);
        ifmap_yid[r*YW +: YW]  = (sel == 2 && r == 5) ? 3'd7 : 3'(6 - r);
        ipsum_yid[r*YW +: YW]  = 3'(r);
        opsum_yid[r*YW +: YW]  = 3'((r * 3) % 7);
      end
    end
    ln_config = (sel == 1) ? 5'h0A : 5'h15;
  endtask

  // Ready source: held high, or pseudo-random under backpressure.
  always begin
    @(posedge clk);
    #1;
    if (bp_mode) begin
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      cfg_ready = lfsr[1];
    end else begin
      cfg_ready = 1'b1;
    end
  end

  // Monitor / scoreboard.
  bit    prev_stall = 1'b0;
  bit    last_pending = 1'b0;
  word_t held;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall   = 1'b0;
      last_pending = 1'b0;
    end else begin
      if (last_pending) begin
        check("done_after_last{done,busy,valid}", 32'({done, busy, cfg_valid}), 32'b100);
        last_pending = 1'b0;
      end
      if (prev_stall) check("stable_during_stall", 32'(cur_word()), 32'(held));
      if (done) done_cnt++;
      if (cfg_valid) seen_first = 1'b1;
      else if (seen_first && busy) gap_cnt++;
      if (cfg_valid && cfg_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h expected none at %0t", cur_word(), $time);
        end else begin
          check("word{busy,word}", 32'({busy, cur_word()}), 32'({1'b1, exp_q.pop_front()}));
        end
        hs_cnt++;
        if (cfg_last) last_pending = 1'b1;
      end
      prev_stall = cfg_valid && !cfg_ready;
      held       = cur_word();
    end
  end

  task automatic do_start();
    push_expected();
    hs_cnt     = 0;
    gap_cnt    = 0;
    done_cnt   = 0;
    seen_first = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit start_in_done);
    bit found = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
    end else if (start_in_done) begin
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
  endtask

  task automatic post_checks(input bit check_gaps);
    repeat (10) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("busy_after_done", 32'(busy), 32'd0);
    if (check_gaps) check("gap_cycles", 32'(gap_cnt), 32'(exp_gaps));
  endtask

  task automatic idle_check(input int n, input string name);
    bit any = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (cfg_valid || busy) any = 1'b1;
    end
    check(name, 32'(any), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, 32'({busy, cfg_valid, cfg_last, done, cfg_class, cfg_is_x, cfg_row, cfg_col,
                     cfg_data}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    cfg_ready = 1'b1;
    apply_pattern(0);
    #23;
    check_reset_outputs("reset_outputs");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_check(20, "idle_no_valid");

    // Full load, ready held high.
    apply_pattern(0);
    do_start();
    wait_done(400, 1'b0);
    post_checks(1'b1);

    // Backpressure.
    bp_mode = 1'b1;
    do_start();
    wait_done(3000, 1'b0);
    post_checks(1'b0);
    bp_mode = 1'b0;

    // Snapshot: inputs change right after start; a mid-load and a DONE-cycle start are ignored.
    apply_pattern(1);
    do_start();
    apply_pattern(0);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(400, 1'b1);
    post_checks(1'b1);

    // Disabled-entry pattern.
    apply_pattern(2);
    do_start();
    wait_done(400, 1'b0);
    post_checks(1'b1);

    // Reset mid-load, then restart.
    apply_pattern(0);
    bp_mode = 1'b1;
    do_start();
    for (int k = 0; k < 2000 && hs_cnt < 100; k++) @(posedge clk);
    check("reached_word_100", 32'(hs_cnt >= 100), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midload_reset_outputs");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_check(10, "idle_after_reset");
    bp_mode = 1'b0;
    do_start();
    wait_done(400, 1'b0);
    post_checks(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
